gate_rebuilder: RTL and testbench

- Receiver-side counterpart of the level-to-edge pulse generator: takes 1-cycle start/stop pulses and rebuilds a clean gate level from them.
- Enforces a minimum gate width and an optional maximum-width timeout.
- Reports the measured width, a timeout flag and protocol errors: stray stop, duplicate start.
- Sits downstream of edge-pulse producers in the ROC front-end control path, feeding gated logic and status registers.

---
 rtl/gate_rebuilder_pkg.sv | 21 ++
 rtl/gate_rebuilder_if.sv | 36 +++
 rtl/gate_rebuilder_sat_counter.sv | 39 +++
 rtl/gate_rebuilder.sv | 135 +++++++++++++
 tb/tb_gate_rebuilder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_rebuilder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gate_rebuilder_pkg : shared types and constants for the gate rebuilder   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package gate_rebuilder_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_GCNT_W = 16;

  localparam logic [DEF_CNT_W-1:0] WIDTH_SAT = {DEF_CNT_W{1'b1}};

  // HOLD: gate is high, a stop has been seen, minimum width not yet reached
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPEN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/gate_rebuilder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gate_rebuilder_if : pulse inputs, width config and status outputs        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface gate_rebuilder_if #(
  parameter int CNT_W  = gate_rebuilder_pkg::DEF_CNT_W,
  parameter int GCNT_W = gate_rebuilder_pkg::DEF_GCNT_W
) ();

  logic              start_i;
  logic              stop_i;
  logic [CNT_W-1:0]  min_width_i;
  logic [CNT_W-1:0]  max_width_i;
  logic              gate_o;
  logic [CNT_W-1:0]  width_o;
  logic              width_vld_o;
  logic              timeout_o;
  logic              stray_stop_o;
  logic              dup_start_o;
  logic [GCNT_W-1:0] gate_cnt_o;

  modport slave (
    input  start_i, stop_i, min_width_i, max_width_i,
    output gate_o, width_o, width_vld_o, timeout_o, stray_stop_o,
           dup_start_o, gate_cnt_o
  );

  modport master (
    output start_i, stop_i, min_width_i, max_width_i,
    input  gate_o, width_o, width_vld_o, timeout_o, stray_stop_o,
           dup_start_o, gate_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/gate_rebuilder_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gate_rebuilder_sat_counter : up-counter, sync clear, sticks at all-ones  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gate_rebuilder_sat_counter #(
  parameter int W = 16
) (
  input  wire logic         clk_i,
  input  wire logic         resetn_i,
  input  wire logic         clr_i,
  input  wire logic         en_i,
  output logic      [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/gate_rebuilder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gate_rebuilder : rebuilds a gate level from start/stop pulses            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gate_rebuilder
  import gate_rebuilder_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GCNT_W = DEF_GCNT_W
) (
  input wire logic          clk_i,
  input wire logic          resetn_i,
  gate_rebuilder_if.slave   bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   min_q, min_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic               gate_q, gate_d;
  logic [CNT_W-1:0]   width_q, width_d;
  logic               vld_q, vld_d;
  logic               to_q, to_d;
  logic               stray_q, stray_d;
  logic               dup_q, dup_d;
  logic [GCNT_W-1:0]  gcnt_q, gcnt_d;

  logic               close_norm;
  logic               close_to;
  logic               open_now;
  logic [CNT_W-1:0]   wcnt;

  // wcnt counts high cycles of gate_o; starts at 1 in the first high cycle
  gate_rebuilder_sat_counter #(
    .W (CNT_W)
  ) u_wcnt (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .clr_i    (close_norm | close_to),
    .en_i     (open_now | (state_q != ST_IDLE)),
    .cnt_o    (wcnt)
  );

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      min_q   <= '0;
      max_q   <= '0;
      gate_q  <= 1'b0;
      width_q <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      stray_q <= 1'b0;
      dup_q   <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      gate_q  <= gate_d;
      width_q <= width_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      stray_q <= stray_d;
      dup_q   <= dup_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // A qualifying stop is checked before the timeout so a coincident stop wins
  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    max_d      = max_q;
    close_norm = 1'b0;
    close_to   = 1'b0;
    open_now   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          open_now = 1'b1;
          state_d  = bus.stop_i ? ST_HOLD : ST_OPEN;
          min_d    = (bus.min_width_i == '0) ? CNT_W'(1) : bus.min_width_i;
          max_d    = bus.max_width_i;
        end
      end
      ST_OPEN: begin
        if (bus.stop_i && (wcnt >= min_q)) begin
          close_norm = 1'b1;
        end else if ((max_q != '0) && (wcnt == max_q)) begin
          close_to = 1'b1;
        end else if (bus.stop_i) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (wcnt >= min_q) begin
          close_norm = 1'b1;
        end else if ((max_q != '0) && (wcnt == max_q)) begin
          close_to = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (close_norm || close_to) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    gate_d  = (state_d != ST_IDLE);
    width_d = width_q;
    vld_d   = close_norm | close_to;
    to_d    = close_to;
    stray_d = (state_q == ST_IDLE) && bus.stop_i && !bus.start_i;
    dup_d   = (state_q != ST_IDLE) && bus.start_i;
    gcnt_d  = gcnt_q;
    if (close_norm || close_to) begin
      width_d = wcnt;
    end
    if (open_now) begin
      gcnt_d = gcnt_q + GCNT_W'(1);
    end
  end

  assign bus.gate_o       = gate_q;
  assign bus.width_o      = width_q;
  assign bus.width_vld_o  = vld_q;
  assign bus.timeout_o    = to_q;
  assign bus.stray_stop_o = stray_q;
  assign bus.dup_start_o  = dup_q;
  assign bus.gate_cnt_o   = gcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_rebuilder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gate_rebuilder : reference-model bench for gate_rebuilder             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_gate_rebuilder;
  import gate_rebuilder_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  gate_rebuilder_if #(.CNT_W(16), .GCNT_W(16)) bus ();

  gate_rebuilder #(.CNT_W(16), .GCNT_W(16)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one open gate with its age, pending-stop flag and
  // the limits captured when it opened.
  int m_open = 0, m_age = 0, m_pend = 0, m_min = 1, m_max = 0;
  int e_gate = 0, e_w = 0, e_vld = 0, e_to = 0, e_stray = 0, e_dup = 0, e_gcnt = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_open = 0; m_age = 0; m_pend = 0; m_min = 1; m_max = 0;
      e_gate = 0; e_w = 0; e_vld = 0; e_to = 0; e_stray = 0; e_dup = 0; e_gcnt = 0;
    end else begin
      e_vld = 0; e_to = 0; e_stray = 0; e_dup = 0;
      if (m_open == 0) begin
        if (bus.start_i) begin
          m_open = 1;
          m_age  = 1;
          m_pend = int'(bus.stop_i);
          m_min  = (bus.min_width_i == 0) ? 1 : int'(bus.min_width_i);
          m_max  = int'(bus.max_width_i);
          e_gcnt = (e_gcnt + 1) % 65536;
        end else if (bus.stop_i) begin
          e_stray = 1;
        end
      end else begin
        if (bus.start_i) e_dup = 1;
        if (bus.stop_i)  m_pend = 1;
        if (m_pend != 0 && m_age >= m_min) begin
          e_vld = 1; e_w = m_age; m_open = 0;
        end else if (m_max != 0 && m_age == m_max) begin
          e_vld = 1; e_to = 1; e_w = m_age; m_open = 0;
        end else if (m_age < int'(WIDTH_SAT)) begin
          m_age++;
        end
      end
      e_gate = m_open;
    end
  end

  // Per-cycle comparison plus event monitors for the directed scenarios
  int hi_cnt = 0, n_vld = 0, n_stray = 0, n_dup = 0, cap_w = 0, cap_to = 0;

  always @(negedge clk) begin
    chk("gate_o",       int'(bus.gate_o),       e_gate);
    chk("width_o",      int'(bus.width_o),      e_w);
    chk("width_vld_o",  int'(bus.width_vld_o),  e_vld);
    chk("timeout_o",    int'(bus.timeout_o),    e_to);
    chk("stray_stop_o", int'(bus.stray_stop_o), e_stray);
    chk("dup_start_o",  int'(bus.dup_start_o),  e_dup);
    chk("gate_cnt_o",   int'(bus.gate_cnt_o),   e_gcnt);
    if (bus.gate_o)       hi_cnt++;
    if (bus.stray_stop_o) n_stray++;
    if (bus.dup_start_o)  n_dup++;
    if (bus.width_vld_o) begin
      n_vld++;
      cap_w  = int'(bus.width_o);
      cap_to = int'(bus.timeout_o);
    end
  end

  task automatic drive(bit s, bit p, int mn, int mx);
    @(posedge clk);
    #2;
    bus.start_i     = s;
    bus.stop_i      = p;
    bus.min_width_i = 16'(mn);
    bus.max_width_i = 16'(mx);
  endtask

  int sc_vld0 = 0;

  task automatic scen_begin();
    @(negedge clk);
    #1;
    hi_cnt  = 0;
    sc_vld0 = n_vld;
  endtask

  task automatic wait_close(string nm, int ew, int eto, int ehi);
    int k;
    k = 0;
    while (n_vld == sc_vld0 && k < 70000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (n_vld == sc_vld0) begin
      chk({nm, "_close_seen"}, 0, 1);
    end else begin
      chk({nm, "_width"},   cap_w,  ew);
      chk({nm, "_timeout"}, cap_to, eto);
      if (ehi >= 0) chk({nm, "_high_cycles"}, hi_cnt, ehi);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.start_i = 1'b0;
    bus.stop_i = 1'b0;
    bus.min_width_i = '0;
    bus.max_width_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gate",  int'(bus.gate_o), 0);
    chk("rst_width", int'(bus.width_o), 0);
    chk("rst_gcnt",  int'(bus.gate_cnt_o), 0);
    @(posedge clk);
    #2 resetn = 1'b1;
    drive(0, 0, 3, 0);

    // Normal close above minimum
    scen_begin();
    drive(1, 0, 3, 0);
    repeat (4) drive(0, 0, 3, 0);
    drive(0, 1, 3, 0);
    drive(0, 0, 3, 0);
    wait_close("t1", 5, 0, 5);
    chk("t1_gcnt", int'(bus.gate_cnt_o), 1);
    drive(0, 0, 0, 0);

    // Early stop held to minimum
    scen_begin();
    drive(1, 0, 8, 0);
    drive(0, 0, 8, 0);
    drive(0, 1, 8, 0);
    drive(0, 0, 8, 0);
    wait_close("t2", 8, 0, 8);
    drive(0, 0, 0, 0);

    // Timeout with no stop
    scen_begin();
    drive(1, 0, 2, 4);
    drive(0, 0, 2, 4);
    wait_close("t3", 4, 1, 4);
    drive(0, 0, 0, 0);

    // Simultaneous start/stop, timeout below minimum
    scen_begin();
    drive(1, 1, 10, 4);
    drive(0, 0, 10, 4);
    wait_close("t4", 4, 1, 4);
    drive(0, 0, 0, 0);

    // Stray stop
    n0 = n_stray;
    drive(0, 1, 1, 0);
    drive(0, 0, 1, 0);
    @(negedge clk); #1;
    chk("stray_count", n_stray - n0, 1);

    // Duplicate start, then restart in the first low cycle
    n0 = n_dup;
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    @(negedge clk); #1;
    chk("dup_count", n_dup - n0, 1);
    chk("dup_gcnt", int'(bus.gate_cnt_o), 5);
    drive(0, 1, 1, 0);
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    @(negedge clk); #1;
    chk("b2b_gate", int'(bus.gate_o), 1);
    chk("b2b_gcnt", int'(bus.gate_cnt_o), 6);
    drive(0, 1, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);

    // Reset mid-gate
    n0 = n_vld;
    drive(1, 0, 1, 0);
    repeat (3) drive(0, 0, 1, 0);
    resetn = 1'b0;
    #1;
    chk("midrst_gate", int'(bus.gate_o), 0);
    chk("midrst_gcnt", int'(bus.gate_cnt_o), 0);
    @(posedge clk);
    #2 resetn = 1'b1;
    repeat (3) drive(0, 0, 1, 0);
    chk("midrst_no_vld", n_vld - n0, 0);

    // Randomized traffic, limits also changing while gates are open
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 6),
            ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8));
    end
    repeat (20) drive(0, 0, 0, 0);

    // Saturation of the width counter with no timeout
    scen_begin();
    drive(1, 0, 0, 0);
    repeat (65540) @(posedge clk);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    wait_close("sat", 65535, 0, -1);
    repeat (3) drive(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
